soc_mult_pipe: RTL

Parametrised, pipelined integer multiplier for the SoC CPU tiles. It generalises the fixed 32×32 low-word multiply cell to any operand width. It computes either the low word or the signed/unsigned high word of the full product (mul / mulxss / mulxsu / mulxuu semantics). A ready/valid handshake with backpressure and a pass-through tag let it sit between the issue stage and the writeback arbiter, or act as a shared coprocessor.

---
 rtl/soc_mult_pipe_if.sv | 27 ++
 rtl/soc_mult_pipe.sv | 125 ++++++++++++
 2 files changed

// File: rtl/soc_mult_pipe_if.sv
// soc_mult_pipe_if: operation request and result handshake bundle
// of the pipelined multiplier.
interface soc_mult_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/soc_mult_pipe.sv
// soc_mult_pipe: three-stage sliced multiplier returning the low or the
// signed/unsigned high word of the full product, tag carried alongside.
module soc_mult_pipe #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16,
    parameter int TAG_W   = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    soc_mult_pipe_if.slave bus,
    output logic           busy
);
    localparam int NS = DATA_W / SLICE_W;
    localparam int PW = 2 * SLICE_W;
    localparam int FW = 2 * DATA_W;

    typedef enum logic [1:0] {
        OP_LO,
        OP_HI_SS,
        OP_HI_SU,
        OP_HI_UU
    } op_e;

    logic              w_adv;
    logic              r_v1, r_v2, r_v3;
    op_e               r_op1, r_op2;
    logic [TAG_W-1:0]  r_tag1, r_tag2, r_tag3;
    logic [DATA_W:0]   r_a1, r_b1;
    logic [PW-1:0]     r_pp [NS][NS];
    logic [DATA_W-1:0] r_corr;
    logic [DATA_W-1:0] r_res;

    assign w_adv          = ~r_v3 | bus.out_ready;
    assign bus.in_ready   = w_adv;
    assign bus.out_valid  = r_v3;
    assign bus.out_result = r_res;
    assign bus.out_tag    = r_tag3;
    assign busy           = r_v1 | r_v2 | r_v3;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= bus.in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    op_e  w_in_op;
    logic w_sx1, w_sx2;

    always_comb begin
        w_in_op = op_e'(bus.in_op);
        w_sx1   = (w_in_op == OP_HI_SS) || (w_in_op == OP_HI_SU);
        w_sx2   = (w_in_op == OP_HI_SS);
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_op1  <= w_in_op;
            r_tag1 <= bus.in_tag;
            r_a1   <= {w_sx1 & bus.in_src1[DATA_W-1], bus.in_src1};
            r_b1   <= {w_sx2 & bus.in_src2[DATA_W-1], bus.in_src2};
        end
    end

    logic [PW-1:0]     w_pp [NS][NS];
    logic [DATA_W-1:0] w_corr;

    always_comb begin
        w_pp = '{default: '0};
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NS; j++) begin
                w_pp[i][j] =
                    {{SLICE_W{1'b0}}, r_a1[i*SLICE_W +: SLICE_W]} *
                    {{SLICE_W{1'b0}}, r_b1[j*SLICE_W +: SLICE_W]};
            end
        end
        // Extension bits weigh -2^DATA_W; only the upper half sees them.
        w_corr = '0
            - (r_a1[DATA_W] ? r_b1[DATA_W-1:0] : '0)
            - (r_b1[DATA_W] ? r_a1[DATA_W-1:0] : '0);
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_pp   <= w_pp;
            r_corr <= w_corr;
            r_op2  <= r_op1;
            r_tag2 <= r_tag1;
        end
    end

    logic [FW-1:0]     w_prod;
    logic [FW-1:0]     w_term;
    logic [DATA_W-1:0] w_sel;

    always_comb begin
        w_prod = {r_corr, {DATA_W{1'b0}}};
        w_term = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NS; j++) begin
                w_term           = '0;
                w_term[PW-1:0]   = r_pp[i][j];
                w_prod = w_prod + (w_term << ((i + j) * SLICE_W));
            end
        end
        w_sel = (r_op2 == OP_LO) ? w_prod[DATA_W-1:0]
                                 : w_prod[FW-1:DATA_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res  <= '0;
            r_tag3 <= '0;
        end else if (w_adv) begin
            r_res  <= w_sel;
            r_tag3 <= r_tag2;
        end
    end
endmodule
